led_bar_arbiter: RTL and testbench
==================================

# led_bar_arbiter

Round-robin scheduler that shares one 16-LED bar among several requesters. Each requester asks for a "bound flash" of its own height. The block grants one requester at a time and runs the flash sequence on the bar: ramp up to the bound, ramp down to zero. It signals completion with a one-cycle `done` pulse. It sits between the control logic that wants LED feedback and the physical `led` outputs, and replaces direct flasher ownership.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LED_W`, 16: LED bar width.
- `BW`, 5: bits per bound field; must hold `LED_W`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req` input `N_REQ`: level request per requester. Must be held until `done`.
- `bound` input `N_REQ*BW`: requester i's bound in bits `[i*BW +: BW]`. Sampled only at grant.
- `gnt` output `N_REQ`: one-hot grant. All zero when idle.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse in the DONE state.
- `aborted` output 1: valid only while `done` is high. 1 if the sequence was cut short.
- `led` output `LED_W`: LED bar, thermometer code from the LSB.

## Operation
- States: IDLE, UP, DOWN, DONE. Internal registers:
  - `cnt`: `BW` bits.
  - `ptr`: last-granted index.
  - `bnd`: latched bound.
  - `sel`: granted index.
- IDLE, with any `req` bit high:
  - Pick the first set bit, searching `ptr+1, ptr+2, …` modulo `N_REQ`.
  - Set `gnt[sel]`, clear `cnt`, clear the abort flag, go to UP.
  - Latch `bnd` = `bound[sel]` clamped to 1..`LED_W`: 0 becomes 1; values above `LED_W` become `LED_W`.
- UP, with `req[sel]` high: `led <= {led[LED_W-2:0],1'b1}`, `cnt <= cnt+1`. When `cnt+1 == bnd`, go to DOWN.
- UP, with `req[sel]` low (abort):
  - `led` and `cnt` hold; set the abort flag; go to DOWN.
  - If `cnt == 0` at abort, go straight to DONE.
- DOWN: `led <= led >> 1`, `cnt <= cnt-1`. When `cnt-1 == 0`, go to DONE. `req` is ignored in DOWN.
- DONE:
  - `done = 1`, `aborted` = abort flag, `gnt` still asserted, `led` = 0.
  - Next edge: clear `gnt`, set `ptr <= sel`, go to IDLE.
- IDLE always lasts at least one cycle between grants. There is no back-to-back grant on the DONE→IDLE edge.
- `led` is always a contiguous run of ones from bit 0, and its popcount equals `cnt`.
- Requests that arrive mid-sequence wait. Non-granted `req` changes never affect the active sequence.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE
  - `gnt`, `led`, `cnt`, `bnd`, `sel` = 0
  - `busy`, `done`, `aborted` = 0
  - `ptr` = `N_REQ-1`, so requester 0 has first priority.
- Reset mid-sequence immediately clears `led` and `gnt`, with no `done` pulse. Pending requests are re-arbitrated from `ptr = N_REQ-1` after release.
- Grant latency: `req` seen high at edge k gives `gnt`/`busy` high after edge k.
- Non-aborted sequence with bound B:
  - First lit LED after edge k+1.
  - All B LEDs lit after edge k+B.
  - `led` = 0 and `done` high after edge k+2B.
  - `gnt` and `busy` low after edge k+2B+1.
- `gnt` is high for exactly 2B+1 cycles. `done` is high for exactly 1 cycle.
- Abort seen at an UP edge with `cnt = c` (`c ≥ 1`): DOWN takes c cycles, then DONE lasts 1 cycle.
- All outputs are registered. `busy` and `done` are decoded directly from state flops and have no combinational path from `req`.

## Test plan
- Reset, then `req = 0001`, `bound0 = 3`:
  - `led` goes 0001, 0011, 0111, 0011, 0001, 0000.
  - `done` pulses once with `aborted = 0`.
  - `gnt = 0001` for 7 cycles.
- `req = 0101` asserted together, bounds 2 and 4:
  - Requester 0 is served first (5 cycles of `gnt`), then one idle cycle, then requester 2 (9 cycles of `gnt`).
- Clamp check:
  - `bound = 0` gives a single-LED flash of 3 cycles.
  - `bound = 20` peaks at `led = 16'hFFFF` and gives 33 cycles of `gnt`.
- Abort: `bound = 16`, drop `req[sel]` after 5 lit LEDs.
  - `led` ramps down from `16'h001F` over 5 cycles.
  - `done` pulses with `aborted = 1`.
- Reset mid-DOWN:
  - `led`, `gnt` and `busy` go to 0 asynchronously, and no `done` occurs.
  - After release, the held request is granted again from priority 0.
- Fairness: all `req` held high, bound 1.
  - Grants rotate 0, 1, 2, 3, 0, …, each 3 cycles long, separated by exactly one idle cycle.

Source files
------------

// File: rtl/led_bar_arbiter.sv
// Round-robin owner of one LED bar: each grant runs a bounded
// ramp-up / ramp-down flash and ends with a one-cycle done pulse.
module led_bar_arbiter #(
  parameter int N_REQ = 4,
  parameter int LED_W = 16,
  parameter int BW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*BW-1:0]   bound,
  output logic [N_REQ-1:0]      gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LED_W-1:0]      led
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t        state;
  logic [BW-1:0] cnt;
  logic [BW-1:0] bnd;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          abrt;

  logic [IW-1:0] pick;
  logic          any;
  logic [BW-1:0] raw;
  logic [BW-1:0] clamp;

  // first requester after the last one served, wrapping
  always_comb begin
    int j;
    j    = 0;
    pick = '0;
    any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any  = 1'b1;
        pick = IW'(j);
      end
    end
  end

  always_comb begin
    raw = bound[pick*BW +: BW];
    if (raw == '0)
      clamp = BW'(1);
    else if (raw > BW'(LED_W))
      clamp = BW'(LED_W);
    else
      clamp = raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      led   <= '0;
      cnt   <= '0;
      bnd   <= '0;
      sel   <= '0;
      ptr   <= IW'(N_REQ-1);
      abrt  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            sel   <= pick;
            gnt   <= ONE << pick;
            cnt   <= '0;
            abrt  <= 1'b0;
            bnd   <= clamp;
            state <= UP;
          end
        end
        UP: begin
          if (req[sel]) begin
            led <= {led[LED_W-2:0], 1'b1};
            cnt <= cnt + 1'b1;
            if (BW'(cnt + 1'b1) == bnd) state <= DOWN;
          end else begin
            // requester let go early: unwind what is lit
            abrt  <= 1'b1;
            state <= (cnt == '0) ? DONE : DOWN;
          end
        end
        DOWN: begin
          led <= led >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == BW'(1)) state <= DONE;
        end
        DONE: begin
          gnt   <= '0;
          led   <= '0;
          ptr   <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign aborted = (state == DONE) & abrt;

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Directed bench for led_bar_arbiter: flash shapes, rotation,
// bound clamping, abort and mid-sequence reset.
module tb_led_bar_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] bound;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] led;

  int n_pass;
  int n_total;

  led_bar_arbiter #(.N_REQ(4), .LED_W(16), .BW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .bound(bound),
    .gnt(gnt), .busy(busy), .done(done),
    .aborted(aborted), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    rst = 1'b1;
  endtask

  // follow one grant until gnt drops; optionally release at done
  task automatic measure(input bit rel, output int n,
                         output logic [15:0] peak, output int nd,
                         output logic ab);
    n = 0; peak = '0; nd = 0; ab = 1'b0;
    while (gnt != '0 && n < 100) begin
      n++;
      peak = peak | led;
      if (done) begin
        nd++;
        ab = aborted;
        if (rel) req = req & ~gnt;
      end
      step();
    end
  endtask

  initial begin
    logic [15:0] exp_led [7];
    int          n;
    int          nd;
    logic [15:0] peak;
    logic        ab;

    n_pass = 0; n_total = 0;
    rst = 1'b0; req = '0; bound = '0;
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0);
    rst = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // basic flash, bound 3
    exp_led = '{16'h0000, 16'h0001, 16'h0003, 16'h0007,
                16'h0003, 16'h0001, 16'h0000};
    bound[0 +: 5] = 5'd3;
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("b3_led%0d", i), led, exp_led[i]);
      chk($sformatf("b3_gnt%0d", i), gnt, 4'b0001);
      chk($sformatf("b3_done%0d", i), done, (i == 6) ? 1 : 0);
      if (i == 6) begin
        chk("b3_abort", aborted, 0);
        req = '0;
      end
    end
    step();
    chk("b3_gnt_off", gnt, 0);
    chk("b3_busy_off", busy, 0);

    // two simultaneous requests
    do_reset();
    bound = '0;
    bound[0 +: 5] = 5'd2;
    bound[10 +: 5] = 5'd4;
    req = 4'b0101;
    step();
    chk("rr_first", gnt, 4'b0001);
    measure(1'b1, n, peak, nd, ab);
    chk("rr_len0", n, 5);
    chk("rr_peak0", peak, 16'h0003);
    chk("rr_done0", nd, 1);
    chk("rr_idle", busy, 0);
    step();
    chk("rr_second", gnt, 4'b0100);
    measure(1'b1, n, peak, nd, ab);
    chk("rr_len2", n, 9);
    chk("rr_peak2", peak, 16'h000F);
    chk("rr_done2", nd, 1);

    // clamp low and high
    bound[15 +: 5] = 5'd0;
    req = 4'b1000;
    step();
    chk("cl0_gnt", gnt, 4'b1000);
    measure(1'b1, n, peak, nd, ab);
    chk("cl0_len", n, 3);
    chk("cl0_peak", peak, 16'h0001);
    bound[5 +: 5] = 5'd20;
    req = 4'b0010;
    step();
    chk("cl20_gnt", gnt, 4'b0010);
    measure(1'b1, n, peak, nd, ab);
    chk("cl20_len", n, 33);
    chk("cl20_peak", peak, 16'hFFFF);
    chk("cl20_abort", ab, 0);

    // abort after 5 lit LEDs
    do_reset();
    bound[0 +: 5] = 5'd16;
    req = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("ab_peak", led, 16'h001F);
    req = '0;
    step();
    chk("ab_hold", led, 16'h001F);
    chk("ab_busy", busy, 1);
    step(); chk("ab_d1", led, 16'h000F);
    step(); chk("ab_d2", led, 16'h0007);
    step(); chk("ab_d3", led, 16'h0003);
    step(); chk("ab_d4", led, 16'h0001);
    step();
    chk("ab_led0", led, 0);
    chk("ab_done", done, 1);
    chk("ab_flag", aborted, 1);
    step();
    chk("ab_gnt_off", gnt, 0);

    // abort before anything lights
    bound[5 +: 5] = 5'd5;
    req = 4'b0010;
    step();
    chk("ab0_gnt", gnt, 4'b0010);
    req = '0;
    step();
    chk("ab0_done", done, 1);
    chk("ab0_flag", aborted, 1);
    chk("ab0_led", led, 0);
    step();
    chk("ab0_idle", busy, 0);

    // reset in the middle of DOWN
    do_reset();
    bound = '0;
    bound[0 +: 5] = 5'd1;
    bound[5 +: 5] = 5'd4;
    req = 4'b0001;
    step();
    measure(1'b1, n, peak, nd, ab);
    chk("mr_pre_len", n, 3);
    req = 4'b0011;
    step();
    chk("mr_gnt1", gnt, 4'b0010);
    for (int i = 0; i < 4; i++) step();
    chk("mr_top", led, 16'h000F);
    step();
    chk("mr_down", led, 16'h0007);
    #2 rst = 1'b0;
    #1;
    chk("mr_led", led, 0);
    chk("mr_gnt", gnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    step();
    chk("mr_done_hold", done, 0);
    rst = 1'b1;
    step();
    chk("mr_regrant", gnt, 4'b0001);
    do_reset();

    // fairness with every requester held
    bound = {4{5'd1}};
    req = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fr_gnt%0d", i), gnt, 4'b0001 << (i % 4));
      measure(1'b0, n, peak, nd, ab);
      chk($sformatf("fr_len%0d", i), n, 3);
      chk($sformatf("fr_idle%0d", i), busy, 0);
      step();
    end
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
